// File: rtl/wifi_phy_pkg.sv
// Shared WiFi PHY definitions: serializer FSM encoding and default FIFO word width.
package wifi_phy_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable serializer shift register; bit order set by FIFO_RD_SER_MSB_FIRST_EN
// (defined: MSB first, shift left; undefined: LSB first, shift right).
module ser_shift_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             R_CLK,
    input  logic             R_rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= din;
        end else if (shift) begin
`ifdef FIFO_RD_SER_MSB_FIRST_EN
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
`else
            shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
`endif
        end
    end

    always_comb begin
`ifdef FIFO_RD_SER_MSB_FIRST_EN
        dout = shreg_q[WIDTH-1];
`else
        dout = shreg_q[0];
`endif
    end

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops words from the TX async FIFO and serialises data_size bits into the PHY bit chain.
// Bit order follows FIFO_RD_SER_MSB_FIRST_EN (see ser_shift_reg).
module fifo_rd_serializer
    import wifi_phy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned SIZE_WIDTH = 32
) (
    input  logic                  R_CLK,
    input  logic                  R_rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SIZE_WIDTH-1:0] data_size,
    input  logic                  R_empty,
    input  logic [DATA_WIDTH-1:0] R_data,
    output logic                  R_inc,
    output logic                  bit_out,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned WORD_CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [WORD_CNT_WIDTH-1:0] FULL_WORD_CNT = WORD_CNT_WIDTH'(DATA_WIDTH);
    localparam logic [SIZE_WIDTH-1:0] FULL_WORD_BITS = SIZE_WIDTH'(DATA_WIDTH);

    ser_state_e state_q, state_d;

    logic [SIZE_WIDTH-1:0]     rem_bits_q, rem_bits_d;
    logic [WORD_CNT_WIDTH-1:0] word_bits_q, word_bits_d;
    logic                      load, shift, shreg_bit;

    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (data_size == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!R_empty) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_ready && word_bits_q == WORD_CNT_WIDTH'(1)) begin
                    state_d = (rem_bits_q == SIZE_WIDTH'(1)) ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        R_inc     = (state_q == StFetch) && !R_empty && !abort;
        bit_valid = (state_q == StShift);
        bit_out   = bit_valid && shreg_bit;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone) && !abort;
        load      = R_inc;
        // An aborted cycle consumes nothing even if the handshake completes.
        shift     = bit_valid && bit_ready && !abort;
    end

    always_comb begin
        rem_bits_d  = rem_bits_q;
        word_bits_d = word_bits_q;
        if (state_q == StIdle && start) begin
            rem_bits_d = data_size;
        end
        if (load) begin
            word_bits_d = (rem_bits_q >= FULL_WORD_BITS) ? FULL_WORD_CNT
                                                         : WORD_CNT_WIDTH'(rem_bits_q);
        end
        if (shift) begin
            rem_bits_d  = rem_bits_q - SIZE_WIDTH'(1);
            word_bits_d = word_bits_q - WORD_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            rem_bits_q  <= '0;
            word_bits_q <= '0;
        end else begin
            rem_bits_q  <= rem_bits_d;
            word_bits_q <= word_bits_d;
        end
    end

    ser_shift_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_shreg (
        .R_CLK   (R_CLK),
        .R_rst_n (R_rst_n),
        .load    (load),
        .shift   (shift),
        .din     (R_data),
        .dout    (shreg_bit)
    );

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Randomised self-checking bench for fifo_rd_serializer against a bit-list reference model.
module tb_fifo_rd_serializer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 32;

    logic          R_CLK = 1'b0;
    logic          R_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] data_size = '0;
    logic          R_empty;
    logic [DW-1:0] R_data;
    logic          R_inc;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready = 1'b0;
    logic          busy;
    logic          done;

    fifo_rd_serializer #(
        .DATA_WIDTH (DW),
        .SIZE_WIDTH (SW)
    ) dut (
        .R_CLK     (R_CLK),
        .R_rst_n   (R_rst_n),
        .start     (start),
        .abort     (abort),
        .data_size (data_size),
        .R_empty   (R_empty),
        .R_data    (R_data),
        .R_inc     (R_inc),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 R_CLK = ~R_CLK;

    int checks = 0;
    int failures = 0;

    // FIFO model: array of words, read pointer advanced on each pop
    logic [DW-1:0] words [0:15];
    int            wr_cnt = 0;
    int            rd_ptr = 0;
    bit            hold = 1'b0;
    assign R_empty = hold || (rd_ptr >= wr_cnt);
    assign R_data  = words[rd_ptr[3:0]];

    always @(posedge R_CLK) begin
        if (R_rst_n && R_inc && !R_empty) rd_ptr <= rd_ptr + 1;
    end

    int cyc = 0;
    always @(posedge R_CLK) cyc <= cyc + 1;

    // bit_ready driver: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random, 3 = manual
    int ready_mode = 0;
    int pat_idx = 0;
    logic [3:0] pat = 4'b1001;
    always @(posedge R_CLK) begin
        #1;
        case (ready_mode)
            0: bit_ready = 1'b1;
            1: begin
                bit_ready = pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end
            2: bit_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor, sampled mid-cycle
    logic got_bits[$];
    int   pops = 0, done_cnt = 0, done_cyc = 0, inc_viol = 0, hold_viol = 0, stall_viol = 0;
    bit   prev_stall = 1'b0, prev_bit = 1'b0, prev_abort = 1'b0;
    int   start_cyc = 0;

    always @(negedge R_CLK) begin
        if (R_rst_n) begin
            if (bit_valid && bit_ready) got_bits.push_back(bit_out);
            if (R_inc) pops++;
            if (R_inc && R_empty) inc_viol++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold && (R_inc || bit_valid)) hold_viol++;
            if (prev_stall && !prev_abort && !(bit_valid && bit_out == prev_bit)) stall_viol++;
            prev_stall = bit_valid && !bit_ready;
            prev_bit   = bit_out;
            prev_abort = abort;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        got_bits.delete();
        pops = 0;
        done_cnt = 0;
        done_cyc = 0;
        hold_viol = 0;
        stall_viol = 0;
    endtask

    task automatic load_words(input int n, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input bit rnd);
        for (int i = 0; i < 16; i++) words[i] = rnd ? DW'($urandom) : '0;
        if (!rnd) begin
            words[0] = w0;
            words[1] = w1;
        end
        rd_ptr = 0;
        wr_cnt = n;
    endtask

    // Reference: bit i of the frame is bit (i mod DW) of word (i / DW) in emission order
    function automatic logic model_bit(input int i);
        int w = i / DW;
        int b = i % DW;
`ifdef FIFO_RD_SER_MSB_FIRST_EN
        return words[w][DW-1-b];
`else
        return words[w][b];
`endif
    endfunction

    function automatic int bit_errors(input int size);
        int errs = 0;
        if (got_bits.size() != size) return -1;
        for (int i = 0; i < size; i++) if (got_bits[i] !== model_bit(i)) errs++;
        return errs;
    endfunction

    task automatic run_frame(input int size, input int hold_cycles, input int max_cyc);
        int n = 0;
        clear_mon();
        @(posedge R_CLK); #1;
        start = 1'b1;
        data_size = SW'(size);
        start_cyc = cyc;
        hold = (hold_cycles > 0);
        @(posedge R_CLK); #1;
        start = 1'b0;
        if (hold_cycles > 0) begin
            repeat (hold_cycles - 1) @(posedge R_CLK);
            #1;
            hold = 1'b0;
        end
        while (done_cnt == 0 && n < max_cyc) begin
            @(posedge R_CLK); #1;
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL frame_timeout size=%0d got done=0 expected done=1", size);
            abort = 1'b1;
            @(posedge R_CLK); #1;
            abort = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({R_inc, bit_out, bit_valid, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=00000",
                     {R_inc, bit_out, bit_valid, busy, done});
        end
        repeat (3) @(posedge R_CLK);
        #1;
        R_rst_n = 1'b1;
        @(posedge R_CLK); #1;
        checks++;
        if ({R_inc, bit_valid, busy, done} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b expected=0000", {R_inc, bit_valid, busy, done});
        end
    endtask

    task automatic test_two_words();
        int e;
        ready_mode = 0;
        load_words(2, 32'hA5A5_0001, 32'hFFFF_0000, 1'b0);
        run_frame(64, 0, 200);
        e = bit_errors(64);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL two_words_bits got_len=%0d errors=%0d expected_len=64 errors=0",
                     got_bits.size(), e);
        end
        checks++;
        if (pops != 2) begin
            failures++;
            $display("FAIL two_words_pops got=%0d expected=2", pops);
        end
        checks++;
        if (done_cyc - start_cyc != 67) begin
            failures++;
            $display("FAIL two_words_done_latency got=%0d expected=67", done_cyc - start_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL two_words_busy_after got=%b expected=0", busy);
        end
    endtask

    task automatic test_partial();
        int e;
        ready_mode = 0;
        load_words(2, 32'h1234_5678, 32'h0000_00FF, 1'b0);
        run_frame(40, 0, 200);
        repeat (3) @(posedge R_CLK);
        #1;
        e = bit_errors(40);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL partial_bits got_len=%0d errors=%0d expected_len=40 errors=0",
                     got_bits.size(), e);
        end
        checks++;
        if (pops != 2 || done_cnt != 1) begin
            failures++;
            $display("FAIL partial_pops_done got=%0d/%0d expected=2/1", pops, done_cnt);
        end
    endtask

    task automatic test_empty_hold();
        int e;
        ready_mode = 0;
        load_words(2, 32'h0, 32'h0, 1'b1);
        run_frame(50, 10, 300);
        e = bit_errors(50);
        checks++;
        if (hold_viol != 0) begin
            failures++;
            $display("FAIL empty_hold_quiet got=%0d expected=0", hold_viol);
        end
        checks++;
        if (e != 0 || pops != 2) begin
            failures++;
            $display("FAIL empty_hold_bits got errors=%0d pops=%0d expected errors=0 pops=2",
                     e, pops);
        end
    endtask

    task automatic test_stall();
        int e, size;
        ready_mode = 1;
        pat_idx = 0;
        size = int'($urandom_range(33, 100));
        load_words((size + DW - 1) / DW, 32'h0, 32'h0, 1'b1);
        run_frame(size, 0, 1000);
        e = bit_errors(size);
        checks++;
        if (e != 0) begin
            failures++;
            $display("FAIL stall_bits size=%0d got_len=%0d errors=%0d expected errors=0",
                     size, got_bits.size(), e);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d expected=0", stall_viol);
        end
        ready_mode = 0;
    endtask

    task automatic test_random();
        int e, size, nw;
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            size = int'($urandom_range(1, 200));
            nw = (size + DW - 1) / DW;
            load_words(nw, 32'h0, 32'h0, 1'b1);
            run_frame(size, int'($urandom_range(0, 3)), size * 8 + 200);
            e = bit_errors(size);
            checks++;
            if (e != 0 || pops != nw || stall_viol != 0) begin
                failures++;
                $display("FAIL random_frame size=%0d got errors=%0d pops=%0d stall=%0d expected 0/%0d/0",
                         size, e, pops, stall_viol, nw);
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_abort();
        int n = 0;
        ready_mode = 3;
        bit_ready = 1'b1;
        load_words(2, 32'h0, 32'h0, 1'b1);
        clear_mon();
        @(posedge R_CLK); #1;
        start = 1'b1;
        data_size = SW'(64);
        @(posedge R_CLK); #1;
        start = 1'b0;
        while (got_bits.size() < 10 && n < 100) begin
            @(negedge R_CLK); #1;
            n++;
        end
        @(posedge R_CLK); #1;
        abort = 1'b1;
        bit_ready = 1'b0;
        @(posedge R_CLK); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got busy=%b valid=%b expected 0 0", busy, bit_valid);
        end
        bit_ready = 1'b1;
        repeat (20) @(posedge R_CLK);
        #1;
        checks++;
        if (pops != 1 || done_cnt != 0 || got_bits.size() != 10) begin
            failures++;
            $display("FAIL abort_after got pops=%0d done=%0d bits=%0d expected 1/0/10",
                     pops, done_cnt, got_bits.size());
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid();
        ready_mode = 0;
        load_words(2, 32'h0, 32'h0, 1'b1);
        clear_mon();
        @(posedge R_CLK); #1;
        start = 1'b1;
        data_size = SW'(64);
        @(posedge R_CLK); #1;
        start = 1'b0;
        repeat (15) @(posedge R_CLK);
        #1;
        R_rst_n = 1'b0;
        #1;
        checks++;
        if ({R_inc, bit_out, bit_valid, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b expected=00000",
                     {R_inc, bit_out, bit_valid, busy, done});
        end
        repeat (2) @(posedge R_CLK);
        #1;
        R_rst_n = 1'b1;
        pops = 0;
        repeat (10) @(posedge R_CLK);
        #1;
        checks++;
        if (pops != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got pops=%0d busy=%b expected 0 0", pops, busy);
        end
    endtask

    task automatic test_zero();
        ready_mode = 0;
        load_words(1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_frame(0, 0, 20);
        checks++;
        if (done_cyc - start_cyc != 1 || pops != 0 || got_bits.size() != 0) begin
            failures++;
            $display("FAIL zero_size got lat=%0d pops=%0d bits=%0d expected 1/0/0",
                     done_cyc - start_cyc, pops, got_bits.size());
        end
    endtask

    task automatic test_bit_order();
        ready_mode = 0;
`ifdef FIFO_RD_SER_MSB_FIRST_EN
        load_words(1, 32'h8000_0000, 32'h0, 1'b0);
`else
        load_words(1, 32'h0000_0001, 32'h0, 1'b0);
`endif
        run_frame(3, 0, 50);
        checks++;
        if (got_bits.size() != 3 || got_bits[0] !== 1'b1 || got_bits[1] !== 1'b0) begin
            failures++;
            $display("FAIL bit_order got len=%0d expected len=3 first=1 second=0",
                     got_bits.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_partial();
        test_empty_hold();
        test_stall();
        test_random();
        test_abort();
        test_reset_mid();
        test_zero();
        test_bit_order();
        checks++;
        if (inc_viol != 0) begin
            failures++;
            $display("FAIL pop_when_empty got=%0d expected=0", inc_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_serializer.md
Name: fifo_rd_serializer

Overview:
- Read-side consumer of the WiFi PHY TX async FIFO, in the R_CLK domain.
- Pops DATA_WIDTH-bit words via the read-pointer's R_inc/R_empty handshake and serialises them one bit per accepted handshake into the PHY TX bit chain (scrambler input).
- Stops after exactly data_size bits, handles a final partial word, and flags frame completion.

Parameters:
- DATA_WIDTH, 32, FIFO word width in bits; must be a power of two.
- SIZE_WIDTH, 32, width of data_size and of the remaining-bit counter.

Ports:
- R_CLK  input  1  read-domain clock
- R_rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begin serialising a frame
- abort  input  1  synchronous abort; return to IDLE, no done pulse
- data_size  input  SIZE_WIDTH  frame length in bits; sampled on accepted start
- R_empty  input  1  FIFO empty flag from read pointer
- R_data  input  DATA_WIDTH  FIFO memory read data at current R_Addr; combinational, valid whenever !R_empty
- R_inc  output  1  pop request to read pointer
- bit_out  output  1  serial data bit
- bit_valid  output  1  bit_out is valid
- bit_ready  input  1  downstream accepts bit this cycle
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, R_rst_n low) values:
  - State = IDLE.
  - R_inc, bit_out, bit_valid, busy and done all 0.
  - Shift register and counters cleared.
  - Reset mid-frame discards the frame; no further pops.
- FSM states are IDLE, FETCH, SHIFT and DONE.
- IDLE:
  - start=1 latches data_size into rem_bits.
  - If data_size==0, go to DONE; otherwise go to FETCH.
  - start is ignored in all other states.
- FETCH:
  - While R_empty=1, hold with R_inc=0.
  - When R_empty=0:
    - R_inc=1 (combinational, exactly this cycle).
    - shreg <= R_data.
    - word_bits <= min(DATA_WIDTH, rem_bits).
    - Go to SHIFT.
  - R_inc is never asserted when R_empty=1.
- SHIFT:
  - bit_valid=1 and bit_out=shreg[0] (LSB first).
  - On bit_valid&&bit_ready:
    - shreg shifts right by 1.
    - rem_bits and word_bits each decrement by 1.
  - If that handshake consumes the last bit of the word (word_bits==1):
    - go to DONE if rem_bits==1;
    - otherwise go to FETCH.
  - bit_out and bit_valid must stay stable while bit_ready=0.
- DONE: done=1 for one cycle, then go to IDLE.
- Partial final word: only the low (rem_bits mod DATA_WIDTH) bits are emitted. The remaining bits are discarded, but the word is still popped (one R_inc).
- abort has priority over every transition in every state except IDLE:
  - next state IDLE, done not pulsed;
  - R_inc forced 0 in the abort cycle.
- Latency:
  - start at cycle N, FIFO non-empty: R_inc at N+1, first bit_valid at N+2.
  - One bubble cycle per word (the FETCH cycle).
  - Total words popped = ceil(data_size/DATA_WIDTH).
- Arithmetic: rem_bits is SIZE_WIDTH wide and never wraps; word_bits is clog2(DATA_WIDTH)+1 wide.

Optional Feature:
- Macro: FIFO_RD_SER_MSB_FIRST_EN.
- Defined:
  - bit_out = shreg[DATA_WIDTH-1], and the register shifts left.
  - Partial final word emits bits [DATA_WIDTH-1 : DATA_WIDTH-rem].
  - Bit count, handshake and timing are unchanged.
- Undefined: LSB-first behaviour as specified above.

Decomposition:
- Shared package wifi_phy_pkg holds:
  - FSM state encoding: IDLE=2'd0, FETCH=2'd1, SHIFT=2'd2, DONE=2'd3;
  - the default word width (32).
- One natural sub-module, ser_shift_reg: loadable shift register with load/shift enables and a direction set by the macro.
- FSM and counters stay in the top.

Test Plan:
- data_size=64, FIFO holds 0xA5A5_0001 then 0xFFFF_0000, bit_ready=1 -> exactly 2 R_inc pulses and 64 bits, LSB first (1,0,0,…); done at start+67 cycles; busy low after done.
- data_size=40, words 0x1234_5678, 0x0000_00FF -> 40 bits: the 32 of word 0, then 8 ones; 2 pops; done once.
- FIFO empty for 10 cycles after start -> R_inc=0 and bit_valid=0 throughout; normal serialisation once R_empty drops.
- bit_ready toggles 1,0,0,1 in SHIFT -> bit_out/bit_valid held during stalls; no bit lost or duplicated (scoreboard compare).
- abort asserted in SHIFT after 10 bits of a 64-bit frame -> IDLE next cycle, no done, no further R_inc. R_rst_n pulsed low mid-frame -> all outputs 0 immediately.
- data_size=0 -> done one cycle after start, zero R_inc; build with FIFO_RD_SER_MSB_FIRST_EN, word 0x8000_0000 -> first bit_out=1.
